psram_tester: RTL

PSRAM_TESTER -- requirements
Module: psram_tester

---
 rtl/psram_tester.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/psram_tester.sv
// Built-in self test for a QPI PSRAM driver: writes a deterministic pattern,
// reads it back, and reports mismatches, the first failing address and timeouts.
module psram_tester #(
    parameter int          NUM_WORDS = 16,
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter logic [23:0] ADDR_STEP = 24'd2,
    parameter logic [15:0] SEED      = 16'hA5C3,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        mem_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        qpi_on,
    input  logic        psram_done,
    input  logic [15:0] psram_rdata,
    output logic [23:0] psram_address,
    output logic        psram_read,
    output logic        psram_write,
    output logic [15:0] psram_wdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  err_count,
    output logic [23:0] fail_addr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_REQ = 3'd1;
    localparam logic [2:0] S_WR_GAP = 3'd2;
    localparam logic [2:0] S_RD_REQ = 3'd3;
    localparam logic [2:0] S_RD_GAP = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]     LAST_IDX = 8'(NUM_WORDS - 1);
    localparam logic [15:0]    PAT_STEP = 16'h0101;

    logic [2:0]    state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic          gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [23:0]   addr_q, addr_d;
    logic [15:0]   pat_q, pat_d;
    logic          pass_q, pass_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    err_q, err_d;
    logic [23:0]   fail_q, fail_d;

    // Address and pattern are kept as running sums so no multiplier is needed.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        fail_d    = fail_q;

        case (state_q)
            S_IDLE: begin
                if (start && qpi_on) begin
                    state_d   = S_WR_REQ;
                    idx_d     = 8'd0;
                    gap_d     = 1'b0;
                    tmo_d     = '0;
                    addr_d    = BASE_ADDR;
                    pat_d     = SEED;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    err_d     = 8'd0;
                    fail_d    = 24'd0;
                end
            end

            S_WR_REQ: begin
                if (psram_done) begin
                    state_d = S_WR_GAP;
                    gap_d   = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_WR_GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else begin
                    tmo_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RD_REQ;
                        idx_d   = 8'd0;
                        addr_d  = BASE_ADDR;
                        pat_d   = SEED;
                    end else begin
                        state_d = S_WR_REQ;
                        idx_d   = idx_q + 8'd1;
                        addr_d  = addr_q + ADDR_STEP;
                        pat_d   = pat_q + PAT_STEP;
                    end
                end
            end

            S_RD_REQ: begin
                if (psram_done) begin
                    state_d = S_RD_GAP;
                    gap_d   = 1'b0;
                    // err_q can never wrap back to zero, so zero means no earlier mismatch.
                    if (psram_rdata != pat_q) begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        if (err_q == 8'd0) begin
                            fail_d = addr_q;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_RD_GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_RD_REQ;
                    tmo_d   = '0;
                    idx_d   = idx_q + 8'd1;
                    addr_d  = addr_q + ADDR_STEP;
                    pat_d   = pat_q + PAT_STEP;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                pass_d  = (err_q == 8'd0) && !timeout_q;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 8'd0;
            gap_q     <= 1'b0;
            tmo_q     <= '0;
            addr_q    <= 24'd0;
            pat_q     <= 16'd0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 8'd0;
            fail_q    <= 24'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            pat_q     <= pat_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
        end
    end

    // Requests decode straight from the state so reset clears them without waiting for a clock.
    assign psram_write   = (state_q == S_WR_REQ);
    assign psram_read    = (state_q == S_RD_REQ);
    assign psram_address = (psram_write || psram_read) ? addr_q : 24'd0;
    assign psram_wdata   = psram_write ? pat_q : 16'd0;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FINISH);
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_count     = err_q;
    assign fail_addr     = fail_q;

endmodule
